// File: rtl/key_debounce_encoder.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_encoder
// Description : Debounces 12 raw piano keys and encodes the highest-priority
//               held key into a registered note number.
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce_encoder #(
    parameter int CLK_DIV  = 1000,
    parameter int STABLE_N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] keys_raw,
    output logic [11:0] keys_db,
    output logic [3:0]  note,
    output logic        note_valid,
    output logic        note_change
);

    localparam int          c_num_keys  = 12;
    localparam logic [15:0] c_presc_max = 16'(CLK_DIV - 1);
    localparam logic [3:0]  c_stable    = 4'(STABLE_N);
    localparam logic [3:0]  c_no_note   = 4'd15;

    logic [11:0] r_sync_meta;
    logic [11:0] r_keys_sync;
    logic [15:0] r_presc;
    logic        w_tick;
    logic [11:0] w_keys_db;
    logic [3:0]  w_note_next;
    logic [3:0]  r_note;
    logic        r_note_valid;
    logic        r_note_change;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_keys_sync <= '0;
        end else begin
            r_sync_meta <= keys_raw;
            r_keys_sync <= r_sync_meta;
        end
    end

    // Prescaler parks at zero while disabled so a re-enable starts a full period.
    assign w_tick = en && (r_presc == c_presc_max);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    for (genvar gi = 0; gi < c_num_keys; gi++) begin : g_key
        logic [3:0] r_cnt;
        logic [3:0] w_cnt_inc;
        logic       r_db;

        assign w_cnt_inc     = r_cnt + 4'd1;
        assign w_keys_db[gi] = r_db;

        // Counter tracks consecutive disagreeing ticks; any agreeing tick restarts it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (w_tick) begin
                if (r_keys_sync[gi] == r_db) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc == c_stable) begin
                    r_db  <= r_keys_sync[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    always_comb begin
        w_note_next = c_no_note;
        for (int i = 0; i < c_num_keys; i++) begin
            if (w_keys_db[i]) begin
                w_note_next = 4'(11 - i);
            end
        end
    end

    // Change is detected against the registered note, so multi-key updates on
    // one tick collapse into a single pulse and reset release never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_note        <= c_no_note;
            r_note_valid  <= 1'b0;
            r_note_change <= 1'b0;
        end else begin
            r_note        <= w_note_next;
            r_note_valid  <= (w_note_next != c_no_note);
            r_note_change <= (w_note_next != r_note);
        end
    end

    assign keys_db     = w_keys_db;
    assign note        = r_note;
    assign note_valid  = r_note_valid;
    assign note_change = r_note_change;

endmodule
`default_nettype wire

// File: doc/key_debounce_encoder.md
KEY_DEBOUNCE_ENCODER -- requirements
Module: key_debounce_encoder

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 1000, setting clk cycles per debounce sample tick (legal range 2..65535).
REQ-002 The block SHALL have parameter STABLE_N, default 4, setting consecutive disagreeing ticks needed to accept a key change (legal range 1..15).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port en  input  1  tick enable; low freezes debounce progress.
REQ-006 The block SHALL have port keys_raw  input  12  asynchronous raw piano keys, bit 11 = highest priority (note C).
REQ-007 The block SHALL have port keys_db  output  12  debounced key state.
REQ-008 The block SHALL have port note  output  4  encoded note 0..11, or 15 when no key is held.
REQ-009 The block SHALL have port note_valid  output  1  high when note != 15.
REQ-010 The block SHALL have port note_change  output  1  single-cycle pulse when note takes a new value.

Function
REQ-011 keys_raw SHALL pass through a 2-flop synchronizer per bit; keys_sync lags keys_raw by exactly 2 cycles.
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0, asserting internal tick for one cycle when count == CLK_DIV-1.
REQ-013 While en=0 the prescaler SHALL hold at 0 and no tick SHALL occur; debounce counters and keys_db SHALL hold.
REQ-014 Each key SHALL have a 4-bit stability counter; on a tick where keys_sync[i] == keys_db[i], counter SHALL clear to 0.
REQ-015 On a tick where keys_sync[i] != keys_db[i] and counter+1 < STABLE_N, counter SHALL increment.
REQ-016 On a tick where keys_sync[i] != keys_db[i] and counter+1 == STABLE_N, keys_db[i] SHALL take keys_sync[i] and counter SHALL clear.
REQ-017 A disagreement lasting fewer than STABLE_N consecutive ticks SHALL be rejected (keys_db unchanged).
REQ-018 note SHALL be registered every cycle from keys_db: highest set index i gives note = 11-i; keys_db == 0 gives 15; latency 1 cycle after keys_db changes.
REQ-019 note_valid SHALL be registered in the same cycle as note and equal (note != 15).
REQ-020 note_change SHALL be high for exactly one cycle, the first cycle note shows a new value; it SHALL stay low while note is constant.
REQ-021 Simultaneous press/release of several keys on one tick SHALL produce one note update and at most one note_change pulse.
REQ-022 Debounced press-to-keys_db latency SHALL lie in [2+(STABLE_N-1)*CLK_DIV+1, 2+STABLE_N*CLK_DIV] cycles with en=1 and clean input.

Reset
REQ-023 While rst=1: sync flops, prescaler, counters, keys_db SHALL be 0; note=15; note_valid=0; note_change=0.
REQ-024 rst SHALL dominate en and all inputs; rst mid-debounce SHALL discard partial counts.
REQ-025 No note_change pulse SHALL occur on the cycle rst deasserts.

Verification (CLK_DIV=4, STABLE_N=3)
REQ-026 keys_raw=12'hFFF, rst=1 for 3 cycles -> keys_db=0, note=15, note_valid=0, note_change=0 during reset and on first cycle after.
REQ-027 keys_raw=12'h001 held, en=1 -> keys_db=12'h001 within cycles 11..14 after change, then note=11, note_valid=1, exactly one note_change pulse.
REQ-028 keys_raw=12'h810 settled -> note=0; then keys_raw=12'h010 -> note=7 after debounce, one pulse per transition.
REQ-029 keys_raw bit 5 high for exactly 2 ticks then low -> keys_db stays 0, note stays 15, no note_change.
REQ-030 en=0 with keys_raw=12'h100 for 50 cycles -> keys_db=0; en raised -> keys_db=12'h100 and note=3 within 14 cycles.
REQ-031 Press key bit 0, assert rst after 2 disagreeing ticks, release rst -> full 3 fresh ticks required before keys_db[0]=1.
